// File: rtl/recip_mul_arbiter.sv
// Round-robin sequencer that shares one external reciprocal-scaling multiplier
// among four requesters. Each transaction goes grant -> multiply -> response.
module recip_mul_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_xncn,
  input  logic [16*NREQ-1:0]   req_onebyn,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_xncn,
  output logic [15:0]          mul_onebyn,
  input  logic [23:0]          mul_op,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [23:0]          rsp_op,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } arbState_e;

  arbState_e   state;
  logic [1:0]  rrPtr;
  logic [1:0]  grantIdx;
  logic        grantAny;
  logic [1:0]  candIdx;
  logic [15:0] xncnLane [NREQ];
  logic [15:0] onebynLane [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : gLane
      assign xncnLane[gi]   = req_xncn[16*gi +: 16];
      assign onebynLane[gi] = req_onebyn[16*gi +: 16];
    end
  endgenerate

  // Walk offsets from the far end so the valid requester nearest rrPtr wins.
  always_comb begin
    grantAny = 1'b0;
    grantIdx = rrPtr;
    candIdx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      candIdx = rrPtr + 2'(k);
      if (req_valid[candIdx]) begin
        grantAny = 1'b1;
        grantIdx = candIdx;
      end
    end
  end

  // The accept pulse must be the same cycle the operands are latched, so it is
  // decoded from the state; gating with rst_n keeps it low while in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grantAny) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rrPtr      <= '0;
      mul_xncn   <= '0;
      mul_onebyn <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_op     <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantAny) begin
            mul_xncn   <= xncnLane[grantIdx];
            mul_onebyn <= onebynLane[grantIdx];
            rsp_id     <= grantIdx;
            rrPtr      <= grantIdx + 2'd1;
            state      <= MUL;
          end
        end
        MUL: begin
          rsp_op    <= mul_op;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_mul_arbiter.sv
// Directed bench for recip_mul_arbiter with a (a*b)>>8 multiplier model.
module tb_recip_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_xncn;
  logic [63:0] req_onebyn;
  logic [3:0]  req_ready;
  logic [15:0] mul_xncn;
  logic [15:0] mul_onebyn;
  logic [23:0] mul_op;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_op;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] ops_done;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  assign mul_op = 24'((32'(mul_xncn) * 32'(mul_onebyn)) >> 8);

  recip_mul_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_xncn  (req_xncn),
    .req_onebyn(req_onebyn),
    .req_ready (req_ready),
    .mul_xncn  (mul_xncn),
    .mul_onebyn(mul_onebyn),
    .mul_op    (mul_op),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic [15:0] x, input logic [15:0] r);
    req_xncn[16*i +: 16]   = x;
    req_onebyn[16*i +: 16] = r;
  endtask

  task automatic expectRsp(input string tag, input int id, input logic [23:0] op);
    checkEq({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    checkEq({tag, "_id"}, 32'(rsp_id), 32'(id));
    checkEq({tag, "_op"}, 32'(rsp_op), 32'(op));
    $display("[TB] txn %s id=%0d op=0x%06h", tag, rsp_id, rsp_op);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    checkEq({tag, "_mul_xncn"}, 32'(mul_xncn), 32'h0);
    checkEq({tag, "_mul_onebyn"}, 32'(mul_onebyn), 32'h0);
    checkEq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    checkEq({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    checkEq({tag, "_rsp_op"}, 32'(rsp_op), 32'h0);
    checkEq({tag, "_busy"}, 32'(busy), 32'h0);
    checkEq({tag, "_ops_done"}, 32'(ops_done), 32'h0);
  endtask

  logic [15:0] xTab  [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
  logic [15:0] rTab  [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
  logic [23:0] rrOp  [4] = '{24'h000100, 24'h000400, 24'h000900, 24'h001000};
  int          gOrder[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_xncn   = '0;
    req_onebyn = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkResetOutputs("reset");

    // Single request from requester 2; T is this cycle.
    @(negedge clk);
    setReq(2, 16'h8400, 16'd100);
    req_valid = 4'b0100;
    #1;
    checkEq("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkEq("t1_req_ready", 32'(req_ready), 32'h0);
    checkEq("t1_mul_xncn", 32'(mul_xncn), 32'h8400);
    checkEq("t1_mul_onebyn", 32'(mul_onebyn), 32'd100);
    checkEq("t1_rsp_valid", 32'(rsp_valid), 32'h0);
    checkEq("t1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    expectRsp("single", 2, 24'h003390);

    // Backpressure for 10 cycles while requester 1 waits.
    setReq(1, 16'h0200, 16'h0300);
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkEq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      checkEq("bp_rsp_id", 32'(rsp_id), 32'h2);
      checkEq("bp_rsp_op", 32'(rsp_op), 32'h003390);
      checkEq("bp_req_ready", 32'(req_ready), 32'h0);
      checkEq("bp_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checkEq("bp_ops_before", 32'(ops_done), 32'h0);
    @(negedge clk);
    #1;
    checkEq("bp_ops_after", 32'(ops_done), 32'h1);
    checkEq("bp_rsp_cleared", 32'(rsp_valid), 32'h0);
    checkEq("bp_idle", 32'(busy), 32'h0);
    checkEq("bp_next_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    expectRsp("second", 1, 24'h000600);
    @(negedge clk);
    #1;
    checkEq("second_ops", 32'(ops_done), 32'h2);

    // Round-robin from reset with all requesters valid.
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) setReq(i, xTab[i], rTab[i]);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkEq("rr_grant", 32'(req_ready), 32'h1 << gOrder[k]);
      @(negedge clk);
      #1;
      checkEq("rr_mul_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      #1;
      expectRsp("rr", gOrder[k], rrOp[gOrder[k]]);
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    checkEq("rr_ops_done", 32'(ops_done), 32'h5);

    // Pointer now at 1; only requester 0 valid.
    req_valid = 4'b0001;
    #1;
    checkEq("skip_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    expectRsp("skip", 0, 24'h000100);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checkEq("skip_ptr", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    expectRsp("after_skip", 1, 24'h000400);
    @(negedge clk);
    #1;
    checkEq("after_skip_ops", 32'(ops_done), 32'h7);

    // Counter wrap: preload 0xFFFF, then one more completion.
    force dut.ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done;
    setReq(3, 16'h0100, 16'h0100);
    req_valid = 4'b1000;
    #1;
    checkEq("wrap_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    expectRsp("wrap", 3, 24'h000100);
    @(negedge clk);
    #1;
    checkEq("wrap_ops", 32'(ops_done), 32'h0);

    // Reset mid-RESP.
    rsp_ready = 1'b0;
    setReq(2, 16'h8400, 16'd100);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    expectRsp("pre_rst", 2, 24'h003390);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkEq("post_rst_busy", 32'(busy), 32'h0);
    checkEq("post_rst_ops", 32'(ops_done), 32'h0);
    checkEq("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkEq("post_rst_req_ready", 32'(req_ready), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
